imem_loader: RTL and testbench

//   Upstream program loader for the instruction memory. Accepts a byte stream
//   (e.g. from a UART receiver), assembles little-endian 32-bit instruction

---
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory: assembles little-endian
// words, writes them into IMEM and holds the core off while loading.
module imem_loader #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic [ADDR_WIDTH+1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  busy,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [7:0]            checksum
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_t                  state, state_n;
   logic [ADDR_WIDTH:0]     count_r;
   logic [ADDR_WIDTH:0]     word_idx;
   logic [ADDR_WIDTH:0]     word_idx_inc;
   logic [1:0]              byte_idx;
   logic [DATA_WIDTH-1:0]   word_buf;
   logic [DATA_WIDTH-1:0]   word_next;
   logic [ADDR_WIDTH+1:0]   addr_r;
   logic [DATA_WIDTH-1:0]   wdata_r;
   logic                    done_r;
   logic                    error_r;
   logic [7:0]              sum_r;
   logic                    idle_like;
   logic                    start_take;
   logic                    cnt_zero;
   logic                    cnt_big;
   logic                    accept;
   logic                    last_byte;
   logic                    last_word;

   assign idle_like    = (state == S_IDLE) || (state == S_DONE);
   assign start_take   = idle_like && start;
   assign cnt_zero     = (word_count == '0);
   assign cnt_big      = (word_count > MAX_WORDS);
   assign word_idx_inc = word_idx + 1'b1;
   assign last_byte    = (byte_idx == 2'd3);
   assign last_word    = (word_idx_inc == count_r);

   always_comb begin
      word_next = word_buf;
      word_next[{byte_idx, 3'b000} +: 8] = byte_data;
   end

   always_comb begin
      state_n    = state;
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      accept     = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               if (cnt_zero)     state_n = S_DONE;
               else if (cnt_big) state_n = S_IDLE;
               else              state_n = S_COLLECT;
            end
         end
         S_COLLECT: begin
            byte_ready = 1'b1;
            accept     = byte_valid;
            if (abort)                      state_n = S_IDLE;
            else if (byte_valid && last_byte) state_n = S_WRITE;
         end
         S_WRITE: begin
            mem_we = 1'b1;
            if (abort)          state_n = S_IDLE;
            else if (last_word) state_n = S_DONE;
            else                state_n = S_COLLECT;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   // Write address/data are captured as the word completes, so they are valid
   // throughout WRITE and naturally hold the last written values afterwards.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r  <= '0;
         word_idx <= '0;
         byte_idx <= '0;
         word_buf <= '0;
         addr_r   <= '0;
         wdata_r  <= '0;
         done_r   <= 1'b0;
         error_r  <= 1'b0;
         sum_r    <= '0;
      end else begin
         if (start_take) begin
            done_r   <= cnt_zero;
            error_r  <= cnt_big;
            sum_r    <= '0;
            byte_idx <= '0;
            word_idx <= '0;
            count_r  <= word_count;
         end
         if (accept) begin
            word_buf <= word_next;
            sum_r    <= sum_r + byte_data;
            byte_idx <= byte_idx + 1'b1;
            if (last_byte && !abort) begin
               addr_r  <= {word_idx[ADDR_WIDTH-1:0], 2'b00};
               wdata_r <= word_next;
            end
         end
         if (state == S_WRITE) begin
            word_idx <= word_idx_inc;
            byte_idx <= '0;
            if (!abort && last_word) done_r <= 1'b1;
         end
      end
   end

   assign busy      = (state == S_COLLECT) || (state == S_WRITE);
   assign cpu_hold  = busy;
   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;
   assign done      = done_r;
   assign error     = error_r;
   assign checksum  = sum_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected writes come from the byte stream
// itself (word k = bytes 4k..4k+3, address 4k), compared as IMEM sees them.
module tb_imem_loader;

   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [AW:0]   word_count;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic [AW+1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_we;
   logic          busy;
   logic          cpu_hold;
   logic          done;
   logic          error;
   logic [7:0]    checksum;

   always #5 clk = ~clk;

   imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .word_count (word_count),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .busy       (busy),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .checksum   (checksum)
   );

   typedef struct {
      logic [AW+1:0] addr;
      logic [31:0]   data;
      int unsigned   cyc;
   } wr_t;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned cyc   = 0;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [7:0]  stream [0:4095];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 4096; i++) stream[i] = 8'($urandom);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"},    byte_ready, 0);
      check({tag, "_addr"},     mem_addr,   0);
      check({tag, "_wdata"},    mem_wdata,  0);
      check({tag, "_we"},       mem_we,     0);
      check({tag, "_busy"},     busy,       0);
      check({tag, "_cpu_hold"}, cpu_hold,   0);
      check({tag, "_done"},     done,       0);
      check({tag, "_error"},    error,      0);
      check({tag, "_checksum"}, checksum,   0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Every mem_we cycle must match the next expected write, one pulse per word.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_we", mem_we, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr",        mem_addr,   mon_e.addr);
            check("wr_data",        mem_wdata,  mon_e.data);
            check("wr_latency",     cyc,        mon_e.cyc);
            check("ready_in_write", byte_ready, 0);
            check("hold_in_write",  cpu_hold,   1);
         end
      end
   end

   // gap_mode: 0 back-to-back, 1 alternate cycles, 2 random gaps.
   task automatic load(input int n, input int gap_mode, input int abort_at, input bit start_mid);
      int         p = 0;
      int         nb = 4 * n;
      int         budget = 4 * n * 8 + 50;
      int         w = 0;
      bit         alt = 1'b1;
      bit         v;
      bit         mid_done = 1'b0;
      bit         aborted = 1'b0;
      logic [7:0] sum = '0;
      wr_t        e;
      start = 1'b1;
      word_count = (AW+1)'(n);
      step();
      start = 1'b0;
      while (p < nb) begin
         if (abort_at >= 0 && p == abort_at) begin
            abort = 1'b1;
            byte_valid = 1'b0;
            step();
            abort = 1'b0;
            aborted = 1'b1;
            break;
         end
         case (gap_mode)
            0:       v = 1'b1;
            1:       begin v = alt; alt = ~alt; end
            default: v = ($urandom_range(99) < 60);
         endcase
         byte_valid = v;
         byte_data  = stream[p];
         start      = 1'b0;
         if (start_mid && p == 512 && !mid_done) begin
            start = 1'b1;
            word_count = (AW+1)'(5);
            mid_done = 1'b1;
         end
         if (v && byte_ready === 1'b1) begin
            sum = sum + stream[p];
            if (p % 4 == 3) begin
               e.addr = (AW+2)'((p / 4) * 4);
               e.data = {stream[p], stream[p-1], stream[p-2], stream[p-3]};
               e.cyc  = cyc + 1;
               exp_q.push_back(e);
            end
            p++;
         end
         step();
         budget--;
         if (budget == 0) begin
            check("byte_timeout", p, nb);
            break;
         end
      end
      byte_valid = 1'b0;
      start = 1'b0;
      if (!aborted) begin
         while (done !== 1'b1 && w < 20) begin
            step();
            w++;
         end
         check("done",       done,          1);
         check("busy_end",   busy,          0);
         check("hold_end",   cpu_hold,      0);
         check("checksum",   checksum,      sum);
         check("writes_out", exp_q.size(),  0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      word_count = '0;
      byte_valid = 1'b0;
      byte_data = '0;
      repeat (3) step();
      check_all_zero("reset");
      reset = 1'b1;
      step();

      // Directed two-word program, back-to-back then with alternate gaps
      stream[0] = 8'h13; stream[1] = 8'h05; stream[2] = 8'h00; stream[3] = 8'h00;
      stream[4] = 8'h93; stream[5] = 8'h00; stream[6] = 8'h10; stream[7] = 8'h00;
      load(2, 0, -1, 1'b0);
      check("dir_checksum", checksum,  8'hBB);
      check("dir_addr",     mem_addr,  12'h004);
      check("dir_wdata",    mem_wdata, 32'h0010_0093);
      load(2, 1, -1, 1'b0);
      check("alt_checksum", checksum,  8'hBB);
      check("alt_wdata",    mem_wdata, 32'h0010_0093);

      // Abort after two bytes of word 1, then a fresh load starts at 0
      fill_random();
      load(3, 0, 6, 1'b0);
      check("abort_busy", busy,         0);
      check("abort_hold", cpu_hold,     0);
      check("abort_done", done,         0);
      check("abort_wr",   exp_q.size(), 0);
      step();
      check("abort_idle", busy, 0);
      fill_random();
      load(1, 2, -1, 1'b0);
      check("reload_addr", mem_addr, 12'h000);

      // Zero-length and oversize requests
      start = 1'b1;
      word_count = '0;
      step();
      start = 1'b0;
      check("zero_done",     done,     1);
      check("zero_busy",     busy,     0);
      check("zero_checksum", checksum, 0);
      start = 1'b1;
      word_count = (AW+1)'(1025);
      step();
      start = 1'b0;
      check("big_error", error, 1);
      check("big_busy",  busy,  0);
      check("big_done",  done,  0);
      step();
      check("big_idle",  busy,  0);

      // Random short loads with random gaps
      for (int k = 0; k < 6; k++) begin
         fill_random();
         load($urandom_range(8, 1), 2, -1, 1'b0);
         check("rand_error", error, 0);
      end

      // Full memory, with an ignored start in the middle
      fill_random();
      load(1024, 0, -1, 1'b1);
      check("full_last_addr", mem_addr,  12'hFFC);
      check("full_last_data", mem_wdata, {stream[4095], stream[4094], stream[4093], stream[4092]});

      // Reset in the middle of a word
      fill_random();
      start = 1'b1;
      word_count = (AW+1)'(2);
      step();
      start = 1'b0;
      byte_valid = 1'b1;
      byte_data = stream[0];
      step();
      byte_data = stream[1];
      step();
      #2 reset = 1'b0;
      #1 check_all_zero("midreset");
      step();
      reset = 1'b1;
      repeat (12) step();
      byte_valid = 1'b0;
      check("post_reset_busy", busy,         0);
      check("post_reset_wr",   exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
